// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, arbiter states and operand widths.
package alu_pkg;

   localparam int OP_W   = 3;
   localparam int OPND_W = 8;
   localparam int RES_W  = 16;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   function automatic logic op_valid(input logic [OP_W-1:0] op);
      return (op >= OP_ADD) && (op <= OP_MUL);
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping upward.
module rr_pick #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]                             i_req,
   input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] i_ptr,
   output logic [NREQ-1:0]                             o_gnt,
   output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_idx,
   output logic                                        o_any
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0] w_k;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_k   = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_k = IW'((int'(i_ptr) + i) % NREQ);
         if (!o_any && i_req[w_k]) begin
            o_any      = 1'b1;
            o_gnt[w_k] = 1'b1;
            o_idx      = w_k;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one start/done ALU between NREQ requesters,
// one command in flight, with a timeout that aborts a command the ALU never finishes.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req,
   input  logic [NREQ-1:0][OPND_W-1:0] req_a,
   input  logic [NREQ-1:0][OPND_W-1:0] req_b,
   input  logic [NREQ-1:0][OP_W-1:0]   req_op,
   output logic [NREQ-1:0]             gnt,
   output logic [NREQ-1:0]             rsp_valid,
   output logic [RES_W-1:0]            rsp_result,
   output logic                        rsp_err,
   output logic                        busy,
   output logic                        alu_start,
   output logic [OPND_W-1:0]           alu_a,
   output logic [OPND_W-1:0]           alu_b,
   output logic [OP_W-1:0]             alu_op,
   input  logic [RES_W-1:0]            alu_result,
   input  logic                        alu_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IW-1:0]       r_rr_ptr;
   logic [IW-1:0]       r_win;
   logic [7:0]          r_cnt;
   logic [NREQ-1:0]     r_gnt;
   logic [NREQ-1:0]     r_rsp_valid;
   logic [RES_W-1:0]    r_rsp_result;
   logic                r_rsp_err;
   logic                r_alu_start;
   logic [OPND_W-1:0]   r_alu_a;
   logic [OPND_W-1:0]   r_alu_b;
   logic [OP_W-1:0]     r_alu_op;

   logic [NREQ-1:0]     w_pick_gnt;
   logic [IW-1:0]       w_pick_idx;
   logic                w_pick_any;
   logic                w_timeout;

   rr_pick #(.NREQ(NREQ)) u_rr_pick (
      .i_req (req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   // Counter holds completed WAIT cycles; this is the last one allowed.
   assign w_timeout = (r_cnt + 8'd1) == 8'(TIMEOUT);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_pick_any) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = op_valid(r_alu_op) ? WAIT : RESP;
         WAIT:    if (alu_done || w_timeout) w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr     <= '0;
         r_win        <= '0;
         r_cnt        <= '0;
         r_gnt        <= '0;
         r_rsp_valid  <= '0;
         r_rsp_result <= '0;
         r_rsp_err    <= 1'b0;
         r_alu_start  <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
      end else begin
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_alu_start <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_pick_any) begin
                  r_gnt    <= w_pick_gnt;
                  r_win    <= w_pick_idx;
                  r_alu_a  <= req_a[w_pick_idx];
                  r_alu_b  <= req_b[w_pick_idx];
                  r_alu_op <= req_op[w_pick_idx];
               end
            end
            ISSUE: begin
               if (op_valid(r_alu_op)) begin
                  r_alu_start <= 1'b1;
                  r_cnt       <= '0;
               end else begin
                  r_rsp_result <= '0;
                  r_rsp_err    <= 1'b0;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt + 8'd1;
               // A done arriving on the final allowed cycle still counts as success.
               if (alu_done) begin
                  r_rsp_result <= alu_result;
                  r_rsp_err    <= 1'b0;
               end else if (w_timeout) begin
                  r_rsp_result <= '0;
                  r_rsp_err    <= 1'b1;
               end
            end
            RESP: begin
               r_rsp_valid <= NREQ'(1) << r_win;
               if (int'(r_win) == NREQ - 1) r_rr_ptr <= '0;
               else                         r_rr_ptr <= r_win + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign gnt        = r_gnt;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_err    = r_rsp_err;
   assign busy       = (r_state != IDLE);
   assign alu_start  = r_alu_start;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_op     = r_alu_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU with programmable latency, scoreboard of expected responses.
module tb_alu_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 15;

   typedef struct {
      int          idx;
      logic [15:0] res;
      logic        err;
   } exp_t;

   logic                  clk    = 1'b0;
   logic                  reset  = 1'b1;
   logic [NREQ-1:0]       req    = '0;
   logic [NREQ-1:0][7:0]  req_a  = '0;
   logic [NREQ-1:0][7:0]  req_b  = '0;
   logic [NREQ-1:0][2:0]  req_op = '0;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_valid;
   logic [15:0]           rsp_result;
   logic                  rsp_err;
   logic                  busy;
   logic                  alu_start;
   logic [7:0]            alu_a;
   logic [7:0]            alu_b;
   logic [2:0]            alu_op;
   logic [15:0]           alu_result;
   logic                  m_done;
   logic                  inj_done = 1'b0;
   logic                  w_alu_done;

   logic                  m_busy;
   int                    m_cnt;
   logic [15:0]           m_res;
   int                    alu_lat  = 2;
   bit                    alu_hang = 1'b0;

   int   cyc     = 0;
   int   n_start = 0;
   int   t_done  = -1;
   int   n_cmp   = 0;
   int   n_err   = 0;
   exp_t exp_q[$];

   assign w_alu_done = m_done | inj_done;

   alu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .gnt        (gnt),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .alu_start  (alu_start),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_done   (w_alu_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd1:    return {8'h00, a} + {8'h00, b};
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   // Behavioural ALU: done arrives alu_lat+1 cycles after the start pulse is seen.
   always @(posedge clk) begin
      if (reset) begin
         m_busy     <= 1'b0;
         m_cnt      <= 0;
         m_done     <= 1'b0;
         m_res      <= '0;
         alu_result <= '0;
      end else begin
         m_done <= 1'b0;
         if (alu_start && !alu_hang && alu_op >= 3'd1 && alu_op <= 3'd4) begin
            m_busy <= 1'b1;
            m_cnt  <= alu_lat;
            m_res  <= ref_alu(alu_op, alu_a, alu_b);
         end else if (m_busy) begin
            if (m_cnt == 1) begin
               m_done     <= 1'b1;
               alu_result <= m_res;
               m_busy     <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (alu_start) n_start <= n_start + 1;
   end

   always @(negedge clk) if (w_alu_done) t_done <= cyc;

   function automatic exp_t pop_exp();
      exp_t e;
      if (exp_q.size() == 0) begin
         e.idx = -1;
         e.res = 16'hxxxx;
         e.err = 1'bx;
      end else begin
         e = exp_q.pop_front();
      end
      return e;
   endfunction

   task automatic wait_gnt(input int budget, output int at, output logic [NREQ-1:0] g);
      at = -1;
      g  = '0;
      for (int i = 0; i < budget && at < 0; i++) begin
         @(negedge clk);
         if (gnt != '0) begin
            at = cyc;
            g  = gnt;
         end
      end
   endtask

   task automatic wait_start(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget && at < 0; i++) begin
         @(negedge clk);
         if (alu_start) at = cyc;
      end
   endtask

   task automatic wait_rsp(input int budget, output int at, output logic [NREQ-1:0] v,
                           output logic [15:0] r, output logic er);
      at = -1;
      v  = '0;
      r  = '0;
      er = 1'b0;
      for (int i = 0; i < budget && at < 0; i++) begin
         @(negedge clk);
         if (rsp_valid != '0) begin
            at = cyc;
            v  = rsp_valid;
            r  = rsp_result;
            er = rsp_err;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req   = '0;
      repeat (2) @(negedge clk);
      n_cmp++; if (gnt !== '0 || rsp_valid !== '0) begin n_err++; $display("FAIL reset_pulses: gnt=%b rsp_valid=%b want 0/0", gnt, rsp_valid); end
      n_cmp++; if (alu_start !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_ctrl: alu_start=%b busy=%b want 0/0", alu_start, busy); end
      n_cmp++; if ({rsp_result, rsp_err} !== 17'd0) begin n_err++; $display("FAIL reset_rsp: result=%h err=%b want 0/0", rsp_result, rsp_err); end
      n_cmp++; if ({alu_a, alu_b, alu_op} !== 19'd0) begin n_err++; $display("FAIL reset_alu_cmd: a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op); end
      reset = 1'b0;
   endtask

   task automatic test_add();
      exp_t e; int tg, tr, s0; logic [NREQ-1:0] g, v; logic [15:0] r; logic er;
      exp_q.push_back('{idx: 0, res: 16'd300, err: 1'b0});
      req_a[0] = 8'd200; req_b[0] = 8'd100; req_op[0] = 3'b001; req[0] = 1'b1;
      s0 = n_start;
      wait_gnt(10, tg, g);
      n_cmp++; if (g !== 4'b0001) begin n_err++; $display("FAIL add_gnt: got %b want 0001", g); end
      req[0] = 1'b0;
      @(negedge clk);
      n_cmp++; if (gnt !== '0 || alu_start !== 1'b1) begin n_err++; $display("FAIL add_start: gnt=%b alu_start=%b want 0000/1", gnt, alu_start); end
      n_cmp++; if ({alu_a, alu_b, alu_op} !== {8'd200, 8'd100, 3'd1}) begin n_err++; $display("FAIL add_operands: a=%0d b=%0d op=%0d want 200/100/1", alu_a, alu_b, alu_op); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b want 1", busy); end
      wait_rsp(40, tr, v, r, er);
      e = pop_exp();
      n_cmp++; if (v !== (4'b0001 << e.idx)) begin n_err++; $display("FAIL add_rsp_valid: got %b want %b", v, 4'b0001 << e.idx); end
      n_cmp++; if (r !== e.res || er !== e.err) begin n_err++; $display("FAIL add_result: got %0d/%b want %0d/%b", r, er, e.res, e.err); end
      n_cmp++; if (n_start - s0 !== 1) begin n_err++; $display("FAIL add_start_count: got %0d want 1", n_start - s0); end
      n_cmp++; if (tr !== t_done + 2) begin n_err++; $display("FAIL add_rsp_latency: rsp at %0d want %0d", tr, t_done + 2); end
   endtask

   task automatic test_mul();
      exp_t e; int tg, tr; logic [NREQ-1:0] g, v; logic [15:0] r; logic er;
      exp_q.push_back('{idx: 2, res: 16'hFE01, err: 1'b0});
      req_a[2] = 8'hFF; req_b[2] = 8'hFF; req_op[2] = 3'b100; req[2] = 1'b1;
      wait_gnt(10, tg, g);
      n_cmp++; if (g !== 4'b0100) begin n_err++; $display("FAIL mul_gnt: got %b want 0100", g); end
      req[2] = 1'b0;
      wait_rsp(40, tr, v, r, er);
      e = pop_exp();
      n_cmp++; if (v !== (4'b0001 << e.idx)) begin n_err++; $display("FAIL mul_rsp_valid: got %b want %b", v, 4'b0001 << e.idx); end
      n_cmp++; if (r !== e.res || er !== e.err) begin n_err++; $display("FAIL mul_result: got %h/%b want %h/%b", r, er, e.res, e.err); end
   endtask

   task automatic test_fairness();
      exp_t e; int tg, tr, tr_prev; logic [NREQ-1:0] g, v; logic [15:0] r; logic er;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i]  = 8'(20 * i + 7);
         req_b[i]  = 8'(3 * i + 5);
         req_op[i] = 3'(i + 1);
      end
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back('{idx: k % NREQ, res: ref_alu(3'((k % NREQ) + 1), 8'(20 * (k % NREQ) + 7), 8'(3 * (k % NREQ) + 5)), err: 1'b0});
      end
      req = 4'hF;
      tr_prev = -1;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(10, tg, g);
         n_cmp++; if (g !== (4'b0001 << (k % NREQ))) begin n_err++; $display("FAIL fair_order_%0d: got %b want %b", k, g, 4'b0001 << (k % NREQ)); end
         if (k > 0) begin
            n_cmp++; if (tg !== tr_prev + 1) begin n_err++; $display("FAIL fair_back_to_back_%0d: gnt at %0d want %0d", k, tg, tr_prev + 1); end
         end
         if (k == 4) req = '0;
         wait_rsp(40, tr, v, r, er);
         e = pop_exp();
         n_cmp++; if (v !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
            n_err++; $display("FAIL fair_rsp_%0d: got %b/%h/%b want %b/%h/%b", k, v, r, er, 4'b0001 << e.idx, e.res, e.err);
         end
         tr_prev = tr;
      end
   endtask

   task automatic test_invalid();
      exp_t e; int tg, tr, s0; logic [NREQ-1:0] g, v; logic [15:0] r; logic er;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back('{idx: 1, res: 16'h0000, err: 1'b0});
         req_a[1] = 8'h33; req_b[1] = 8'h44; req_op[1] = (k == 0) ? 3'b000 : 3'b111; req[1] = 1'b1;
         s0 = n_start;
         wait_gnt(10, tg, g);
         n_cmp++; if (g !== 4'b0010) begin n_err++; $display("FAIL inv_gnt_%0d: got %b want 0010", k, g); end
         req[1] = 1'b0;
         wait_rsp(20, tr, v, r, er);
         e = pop_exp();
         n_cmp++; if (tr !== tg + 2) begin n_err++; $display("FAIL inv_latency_%0d: rsp at %0d want %0d", k, tr, tg + 2); end
         n_cmp++; if (n_start !== s0) begin n_err++; $display("FAIL inv_no_start_%0d: starts %0d want 0", k, n_start - s0); end
         n_cmp++; if (v !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
            n_err++; $display("FAIL inv_rsp_%0d: got %b/%h/%b want %b/%h/%b", k, v, r, er, 4'b0001 << e.idx, e.res, e.err);
         end
      end
   endtask

   task automatic test_timeout();
      exp_t e; int tg, ts, tr; logic [NREQ-1:0] g, v; logic [15:0] r; logic er;
      alu_hang = 1'b1;
      exp_q.push_back('{idx: 3, res: 16'h0000, err: 1'b1});
      req_a[3] = 8'd5; req_b[3] = 8'd6; req_op[3] = 3'b001; req[3] = 1'b1;
      wait_gnt(10, tg, g);
      n_cmp++; if (g !== 4'b1000) begin n_err++; $display("FAIL to_gnt: got %b want 1000", g); end
      req[3] = 1'b0;
      wait_start(5, ts);
      n_cmp++; if (ts !== tg + 1) begin n_err++; $display("FAIL to_start: at %0d want %0d", ts, tg + 1); end
      wait_rsp(40, tr, v, r, er);
      e = pop_exp();
      n_cmp++; if (tr !== ts + TIMEOUT + 1) begin n_err++; $display("FAIL to_latency: rsp at %0d want %0d", tr, ts + TIMEOUT + 1); end
      n_cmp++; if (v !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
         n_err++; $display("FAIL to_rsp: got %b/%h/%b want %b/%h/%b", v, r, er, 4'b0001 << e.idx, e.res, e.err);
      end
      alu_hang = 1'b0;
      @(negedge clk); inj_done = 1'b1;
      @(negedge clk); inj_done = 1'b0;
      wait_rsp(6, tr, v, r, er);
      n_cmp++; if (tr !== -1) begin n_err++; $display("FAIL to_late_done: rsp_valid=%b at %0d want none", v, tr); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_done_at_timeout();
      exp_t e; int tg, ts, tr; logic [NREQ-1:0] g, v; logic [15:0] r; logic er;
      alu_lat = TIMEOUT - 2;
      exp_q.push_back('{idx: 2, res: 16'h00AA, err: 1'b0});
      req_a[2] = 8'hA5; req_b[2] = 8'h0F; req_op[2] = 3'b011; req[2] = 1'b1;
      wait_gnt(10, tg, g);
      req[2] = 1'b0;
      wait_start(5, ts);
      wait_rsp(40, tr, v, r, er);
      e = pop_exp();
      n_cmp++; if (t_done !== ts + TIMEOUT - 1) begin n_err++; $display("FAIL edge_done_cycle: done at %0d want %0d", t_done, ts + TIMEOUT - 1); end
      n_cmp++; if (tr !== ts + TIMEOUT + 1) begin n_err++; $display("FAIL edge_latency: rsp at %0d want %0d", tr, ts + TIMEOUT + 1); end
      n_cmp++; if (v !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
         n_err++; $display("FAIL edge_done_wins: got %b/%h/%b want %b/%h/%b", v, r, er, 4'b0001 << e.idx, e.res, e.err);
      end
      alu_lat = 2;
   endtask

   task automatic test_reset_mid_wait();
      exp_t e; int tg, ts, tr; logic [NREQ-1:0] g, v; logic [15:0] r; logic er;
      alu_lat = 10;
      req_a[3] = 8'h12; req_b[3] = 8'h34; req_op[3] = 3'b100; req[3] = 1'b1;
      wait_gnt(10, tg, g);
      n_cmp++; if (g !== 4'b1000) begin n_err++; $display("FAIL rst_mul_gnt: got %b want 1000", g); end
      req[3] = 1'b0;
      wait_start(5, ts);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || gnt !== '0 || rsp_valid !== '0 || alu_start !== 1'b0) begin
         n_err++; $display("FAIL rst_mid_ctrl: busy=%b gnt=%b rsp_valid=%b start=%b want all 0", busy, gnt, rsp_valid, alu_start);
      end
      n_cmp++; if ({rsp_result, rsp_err, alu_a, alu_b, alu_op} !== 36'd0) begin
         n_err++; $display("FAIL rst_mid_data: result=%h err=%b a=%h b=%h op=%h want 0", rsp_result, rsp_err, alu_a, alu_b, alu_op);
      end
      reset   = 1'b0;
      alu_lat = 2;
      wait_rsp(14, tr, v, r, er);
      n_cmp++; if (tr !== -1) begin n_err++; $display("FAIL rst_no_rsp: rsp_valid=%b at %0d want none", v, tr); end
      req_a[1] = 8'd40; req_b[1] = 8'd2; req_op[1] = 3'b001;
      req_a[3] = 8'd9;  req_b[3] = 8'd9; req_op[3] = 3'b001;
      exp_q.push_back('{idx: 1, res: 16'd42, err: 1'b0});
      exp_q.push_back('{idx: 3, res: 16'd18, err: 1'b0});
      req = 4'b1010;
      for (int k = 0; k < 2; k++) begin
         wait_gnt(10, tg, g);
         n_cmp++; if (g !== (4'b0001 << exp_q[0].idx)) begin n_err++; $display("FAIL rst_after_gnt_%0d: got %b want %b", k, g, 4'b0001 << exp_q[0].idx); end
         req = req & ~g;
         wait_rsp(40, tr, v, r, er);
         e = pop_exp();
         n_cmp++; if (v !== (4'b0001 << e.idx) || r !== e.res || er !== e.err) begin
            n_err++; $display("FAIL rst_after_rsp_%0d: got %b/%0d/%b want %b/%0d/%b", k, v, r, er, 4'b0001 << e.idx, e.res, e.err);
         end
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_fairness();
      test_invalid();
      test_timeout();
      test_done_at_timeout();
      test_reset_mid_wait();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 8-bit ALU (ADD/AND/XOR/MUL, start/done handshake, 16-bit result) between NREQ requesters. Arbitrates round-robin, latches the winner's operands, and drives the ALU's start/A/B/op. It waits for done, or a timeout, then returns the result to the winner only. It sits between the requesting engines and the ALU instance, and is the only driver of the ALU's command inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 15, maximum WAIT cycles before the command is aborted (1..255)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request, held until gnt
- req_a  in  NREQ x 8  operand A per requester
- req_b  in  NREQ x 8  operand B per requester
- req_op  in  NREQ x 3  opcode per requester
- gnt  out  NREQ  one-hot, 1-cycle pulse: command accepted
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: response for that requester
- rsp_result  out  16  result, valid with any rsp_valid bit
- rsp_err  out  1  timeout flag, valid with any rsp_valid bit
- busy  out  1  high in every state except IDLE
- alu_start  out  1  1-cycle start pulse to the ALU
- alu_a, alu_b  out  8  latched operands to the ALU
- alu_op  out  3  latched opcode to the ALU
- alu_result  in  16  ALU result
- alu_done  in  1  ALU completion

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req bit is set:
  - Winner = first set bit at or after rr_ptr, searching upward with wrap.
  - Latch the winner's a/b/op and index.
  - Pulse gnt[winner].
  - Go to ISSUE.
- ISSUE, valid op (001..100):
  - alu_start=1 for this cycle only.
  - Clear the timeout counter.
  - Go to WAIT.
- ISSUE, invalid op (000, 101..111): do not start the ALU. Set result 0, err 0, go to RESP. The ALU never signals done for these ops.
- WAIT:
  - alu_a/alu_b/alu_op stay stable.
  - Counter increments each cycle.
  - alu_done=1: capture alu_result, err=0, go to RESP.
  - Counter reaches TIMEOUT without done: result 0, err=1, go to RESP.
  - done and timeout in the same cycle: done wins.
- RESP:
  - Pulse rsp_valid[winner] with rsp_result/rsp_err.
  - rr_ptr = (winner+1) mod NREQ.
  - Go to IDLE.
- alu_done outside WAIT is ignored.
- Requester rules:
  - A requester that keeps req high after its gnt is treated as a new request.
  - req dropped before gnt is legal. That request is withdrawn.
- Widths: results are passed through unmodified from the ALU (16 bits). AND/XOR results are zero-extended by the ALU.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - state=IDLE, rr_ptr=0, counter=0.
  - gnt, rsp_valid, alu_start, busy = 0.
  - rsp_result=0, rsp_err=0, alu_a=alu_b=0, alu_op=0.
  - An in-flight command is dropped with no response.
  - The ALU must be reset in the same cycle.
- gnt is asserted in the cycle after req is sampled in IDLE (registered output).
- alu_start is 1 cycle after gnt.
- rsp_valid is 1 cycle after the edge where alu_done is sampled in WAIT.
- Invalid op: rsp_valid is 2 cycles after gnt.
- Timeout: rsp_valid is TIMEOUT+1 cycles after the last WAIT entry.
- Back-to-back: the next gnt can occur 1 cycle after rsp_valid (RESP→IDLE→grant).
- Only one command is ever in flight. There is no pipelining across requesters.

## Structure
- alu_pkg holds shared definitions:
  - op enum: OP_NOP=3'b000, OP_ADD=3'b001, OP_AND=3'b010, OP_XOR=3'b011, OP_MUL=3'b100.
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - Function op_valid(op).
- The ALU's own state enum stays local to the ALU.
- Sub-module rr_pick: combinational round-robin picker. Inputs are the req vector and ptr; outputs are one-hot grant, index, and any. It is parameterised by NREQ and instantiated once.

## Test plan
- Single ADD: req[0], a=8'd200, b=8'd100, op=001 → gnt[0] pulse, one alu_start, rsp_valid[0] with rsp_result=16'd300, rsp_err=0.
- MUL: req[2], a=8'hFF, b=8'hFF, op=100 → rsp_result=16'hFE01, delivered only on rsp_valid[2].
- Fairness: all four req held high, each then re-asserted → grant order 0,1,2,3,0. rr_ptr is observed to wrap 3→0.
- Invalid op: op=000, then op=111 → no alu_start, rsp_valid 2 cycles after gnt, result 0, err 0.
- Timeout: ALU model holds alu_done low, TIMEOUT=15 → rsp_err=1, result 0, 16 cycles after alu_start. A late alu_done afterwards is ignored.
- Reset mid-WAIT: assert reset during a MUL → next cycle all outputs are 0 and state is IDLE. No rsp_valid. The following req[1] is granted first (rr_ptr=0 skips the idle req[0]).
